// File: rtl/spi_reg_ctrl.sv
// Command sequencer between the SPI slave byte interface and the register bus:
// decodes an SSEL-framed command byte, then streams writes/reads with address auto-increment.
module spi_reg_ctrl #(
  parameter int         AUTO_INC  = 1,
  parameter int         TIMEOUT   = 15,
  parameter logic [5:0] STATUS_ID = 6'h25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic       busy,
  output logic       ovr_flag,
  output logic       to_flag
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WR_DATA, S_WR_WAIT, S_RD_WAIT, S_RD_DATA
  } state_t;

  localparam logic [6:0] ADDR_STEP = (AUTO_INC != 0) ? 7'd1 : 7'd0;
  localparam logic [7:0] TO_LIM    = 8'(TIMEOUT);

  state_t     r_state, w_nxt;
  logic [7:0] r_tx, w_tx;
  logic [6:0] r_addr, w_addr;
  logic [7:0] r_wdata, w_wdata;
  logic       r_we, w_we, r_re, w_re;
  logic       r_busy, w_busy;
  logic       r_ovr, w_ovr, r_to, w_to;
  logic [7:0] r_cnt, w_cnt;
  logic       w_tout;
  logic [6:0] w_adv;

  assign w_tout = (r_cnt == TO_LIM);
  assign w_adv  = r_addr + ADDR_STEP;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  // frame_start outranks frame_end; frame_end outranks every in-frame event
  always_comb begin
    w_nxt = r_state;
    if (frame_start)    w_nxt = S_CMD;
    else if (frame_end) w_nxt = S_IDLE;
    else begin
      case (r_state)
        S_CMD:     if (rx_valid) w_nxt = rx_data[7] ? S_RD_WAIT : S_WR_DATA;
        S_WR_DATA: if (rx_valid) w_nxt = S_WR_WAIT;
        S_WR_WAIT: if (reg_ack || w_tout) w_nxt = S_WR_DATA;
        S_RD_WAIT: if (reg_ack || w_tout) w_nxt = S_RD_DATA;
        S_RD_DATA: if (rx_valid) w_nxt = S_RD_WAIT;
        default:   w_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_tx    = r_tx;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_we    = r_we;
    w_re    = r_re;
    w_ovr   = r_ovr;
    w_to    = r_to;
    w_cnt   = r_cnt;
    w_busy  = (w_nxt != S_IDLE);
    if (frame_start) begin
      w_tx  = {r_ovr, r_to, STATUS_ID};
      w_ovr = 1'b0;
      w_to  = 1'b0;
      w_we  = 1'b0;
      w_re  = 1'b0;
      w_cnt = '0;
    end else if (frame_end) begin
      w_we  = 1'b0;
      w_re  = 1'b0;
      w_cnt = '0;
    end else begin
      case (r_state)
        S_CMD: if (rx_valid) begin
          w_addr = rx_data[6:0];
          w_cnt  = '0;
          if (rx_data[7]) w_re = 1'b1;
          else            w_tx = 8'h00;
        end
        S_WR_DATA: if (rx_valid) begin
          w_wdata = rx_data;
          w_we    = 1'b1;
          w_cnt   = '0;
        end
        S_WR_WAIT: begin
          if (rx_valid) w_ovr = 1'b1;
          if (reg_ack) begin
            w_we   = 1'b0;
            w_addr = w_adv;
          end else if (w_tout) begin
            w_we   = 1'b0;
            w_to   = 1'b1;
            w_addr = w_adv;
          end else w_cnt = r_cnt + 8'd1;
        end
        // a timed-out read still advances the address, like a timed-out write
        S_RD_WAIT: begin
          if (rx_valid) w_ovr = 1'b1;
          if (reg_ack) begin
            w_re = 1'b0;
            w_tx = reg_rdata;
          end else if (w_tout) begin
            w_re   = 1'b0;
            w_to   = 1'b1;
            w_tx   = 8'hFF;
            w_addr = w_adv;
          end else w_cnt = r_cnt + 8'd1;
        end
        S_RD_DATA: if (rx_valid) begin
          w_addr = w_adv;
          w_re   = 1'b1;
          w_cnt  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_tx    <= w_tx;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_we    <= w_we;
      r_re    <= w_re;
      r_busy  <= w_busy;
      r_ovr   <= w_ovr;
      r_to    <= w_to;
      r_cnt   <= w_cnt;
    end
  end

  assign tx_data   = r_tx;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign busy      = r_busy;
  assign ovr_flag  = r_ovr;
  assign to_flag   = r_to;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboarded bench for spi_reg_ctrl: frame-level model predicts bus transactions,
// MISO bytes and flags; a negedge monitor compares whatever the DUT presents.
module tb_spi_reg_ctrl;
  localparam int TO  = 15;
  localparam int GAP = 20;

  logic       clk, resetn, frame_start, frame_end, rx_valid;
  logic [7:0] rx_data, tx_data, reg_wdata, reg_rdata;
  logic [6:0] reg_addr;
  logic       reg_we, reg_re, reg_ack, busy, ovr_flag, to_flag;
  logic       slave_ack, stray_ack;

  spi_reg_ctrl #(.AUTO_INC(1), .TIMEOUT(TO), .STATUS_ID(6'h25)) dut (
    .clk(clk), .resetn(resetn), .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .busy(busy), .ovr_flag(ovr_flag), .to_flag(to_flag)
  );

  assign reg_ack = slave_ack | stray_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_delay = 2;
  bit meas_to = 1'b0;
  bit m_ovr = 1'b0, m_to = 1'b0;
  logic [7:0]  fd [4];
  logic [14:0] wq [$];
  logic [6:0]  rq [$];
  logic [7:0]  mq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
  endtask

  // register slave: acks ack_delay cycles after a request appears (never if <= 0)
  initial begin
    int age;
    age = 0; slave_ack = 1'b0; reg_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      slave_ack = 1'b0;
      if (!resetn || !(reg_we || reg_re)) age = 0;
      else begin
        age++;
        if (ack_delay > 0 && age == ack_delay) begin
          slave_ack = 1'b1;
          reg_rdata = {1'b0, reg_addr} ^ 8'h3C;
        end
      end
    end
  end

  // monitor: one MISO byte per rx_valid, one transaction per request rising edge
  initial begin
    logic p_we, p_re;
    logic [14:0] w;
    p_we = 1'b0; p_re = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (mq.size() == 0) begin total++; bad++; $display("FAIL miso_unexp actual=%0h required=none", tx_data); end
        else chk("miso", 32'(tx_data), 32'(mq.pop_front()));
      end
      if (reg_we && !p_we) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexp actual=%0h/%0h required=none", reg_addr, reg_wdata);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(reg_addr), 32'(w[14:8]));
          chk("wr_data", 32'(reg_wdata), 32'(w[7:0]));
        end
      end
      if (reg_re && !p_re) begin
        if (rq.size() == 0) begin total++; bad++; $display("FAIL rd_unexp actual=%0h required=none", reg_addr); end
        else chk("rd_addr", 32'(reg_addr), 32'(rq.pop_front()));
      end
      p_we = reg_we; p_re = reg_re;
    end
  end

  task automatic frame_open(input int adly, output logic [7:0] st);
    st = {m_ovr, m_to, 6'h25};
    m_ovr = 1'b0; m_to = 1'b0; ack_delay = adly;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("status", 32'(tx_data), 32'(st));
    chk("to_clr", 32'(to_flag), 32'd0);
    chk("ovr_clr", 32'(ovr_flag), 32'd0);
    chk("busy_on", 32'(busy), 32'd1);
    mq.push_back(st);
    tick(); tick();
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int nb, input int adly, input bit ovr_inj);
    logic [6:0] a;
    logic [7:0] st, r;
    int n;
    frame_open(adly, st);
    a = cmd[6:0];
    if (!cmd[7]) begin
      send(cmd);
      for (int i = 0; i < nb; i++) begin
        repeat (GAP) tick();
        mq.push_back(8'h00);
        wq.push_back({a, fd[i]});
        send(fd[i]);
        if (ovr_inj && i == 0) begin
          tick(); tick();
          mq.push_back(8'h00);
          send(8'h99);
          m_ovr = 1'b1;
          chk("ovr_set", 32'(ovr_flag), 32'd1);
        end
        if (adly <= 0) m_to = 1'b1;
        a = a + 7'd1;
      end
    end else begin
      rq.push_back(a);
      send(cmd);
      if (meas_to) begin
        n = 0;
        while (reg_re && n < 40) begin tick(); n++; end
        chk("to_len", 32'(n), 32'(TO + 1));
        chk("to_tx", 32'(tx_data), 32'hFF);
        chk("to_flag", 32'(to_flag), 32'd1);
      end
      for (int i = 0; i <= nb; i++) begin
        repeat (GAP) tick();
        if (adly <= 0) begin r = 8'hFF; m_to = 1'b1; a = a + 7'd1; end
        else r = {1'b0, a} ^ 8'h3C;
        if (i < nb) begin
          mq.push_back(r);
          a = a + 7'd1;
          rq.push_back(a);
          send(8'($urandom));
        end
      end
    end
    repeat (GAP) tick();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("busy_off", 32'(busy), 32'd0);
    chk("we_off", 32'(reg_we), 32'd0);
    chk("re_off", 32'(reg_re), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_tx"}, 32'(tx_data), 32'd0);
    chk({nm, "_addr"}, 32'(reg_addr), 32'd0);
    chk({nm, "_wdata"}, 32'(reg_wdata), 32'd0);
    chk({nm, "_we"}, 32'(reg_we), 32'd0);
    chk({nm, "_re"}, 32'(reg_re), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_ovr"}, 32'(ovr_flag), 32'd0);
    chk({nm, "_to"}, 32'(to_flag), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st;
    resetn = 1'b0; frame_start = 1'b0; frame_end = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; stray_ack = 1'b0;
    repeat (3) tick();
    chk_zero("rst");
    resetn = 1'b1; tick();

    // write burst
    fd[0] = 8'hAA; fd[1] = 8'h55;
    run_frame(8'h10, 2, 2, 1'b0);
    // read burst across the address wrap
    run_frame(8'hFF, 2, 2, 1'b0);
    // read timeout; the following frame reports it in the status byte
    meas_to = 1'b1;
    run_frame(8'h85, 0, 0, 1'b0);
    meas_to = 1'b0;
    // overrun during WR_WAIT
    fd[0] = 8'h5A;
    run_frame(8'h20, 1, 6, 1'b1);

    // abort a pending read, then a stray ack
    frame_open(0, st);
    rq.push_back(7'h30);
    send(8'hB0);
    repeat (3) tick();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("abort_re", 32'(reg_re), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    stray_ack = 1'b1; tick(); stray_ack = 1'b0;
    repeat (GAP) tick();
    chk("abort_to", 32'(to_flag), 32'd0);
    chk("abort_ovr", 32'(ovr_flag), 32'd0);
    chk("abort_re2", 32'(reg_re), 32'd0);
    chk("abort_tx", 32'(tx_data), 32'(st));

    // asynchronous reset while a write is waiting
    frame_open(0, st);
    send(8'h40);
    repeat (3) tick();
    mq.push_back(8'h00);
    wq.push_back({7'h40, 8'h5A});
    send(8'h5A);
    repeat (3) tick();
    resetn = 1'b0; #1;
    chk_zero("midrst");
    m_ovr = 1'b0; m_to = 1'b0;
    tick(); tick();
    resetn = 1'b1; tick();

    // randomized frames
    for (int k = 0; k < 30; k++) begin
      int nb, adly;
      nb = int'($urandom_range(1, 3));
      adly = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6));
      for (int j = 0; j < 4; j++) fd[j] = 8'($urandom);
      run_frame(8'($urandom), nb, adly, ($urandom_range(0, 3) == 0) && (adly >= 4));
    end

    repeat (5) tick();
    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("rq_left", 32'(rq.size()), 32'd0);
    chk("mq_left", 32'(mq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
